fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer. Owns the fetch PC and drives a single-outstanding instruction-memory request port.
//  Arbitrates PC sources: trap > decode redirect > sequential. Buffers one fetched instruction for decode under stall_F.
//  Discards in-flight responses made stale by a redirect. Sits between the hazard unit/decode redirect logic and imem.
// PARAMETERS
//  RESET_PC  32'h8000_0000  fetch PC loaded on reset
//  PC_STEP   1              sequential increment (word-addressed imem)
//  ADDR_W    32             PC/address width
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous, active-high reset
//  stall_F_i      in   1       decode cannot take an instruction this cycle
//  redirect_D_i   in   1       decode branch/jump taken
//  target_D_i     in   ADDR_W  decode redirect target
//  trap_i         in   1       trap/exception redirect (wins over redirect_D_i)
//  trap_vec_i     in   ADDR_W  trap target
//  imem_req_o     out  1       request valid
//  imem_addr_o    out  ADDR_W  request address
//  imem_gnt_i     in   1       request accepted this cycle
//  imem_rvalid_i  in   1       response valid (>=1 cycle after gnt)
//  imem_rdata_i   in   32      response instruction
//  valid_F_o      out  1       instr_F_o/pc_F_o valid for decode
//  instr_F_o      out  32      fetched instruction
//  pc_F_o         out  ADDR_W  PC of instr_F_o
//  flush_D_o      out  1       combinational pulse: redirect taken this cycle
// BEHAVIOUR
//  Reset: state=IDLE, pc_r=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, valid_F_o=0, instr_F_o=0, pc_F_o=RESET_PC.
//  Reset mid-transfer: all in-flight state dropped; post-reset responses still count (state DROP not entered).
//  redir = trap_i | redirect_D_i; tgt = trap_i ? trap_vec_i : target_D_i. Redirect ignores stall_F_i.
//  On redir: flush_D_o=1 same cycle; pc_r<=tgt; valid_F_o<=0 next edge.
//  FSM:
//   IDLE: go REQ when buffer free (!valid_F_o or consumed this cycle) and no redir-then-DROP pending.
//   REQ:  imem_req_o=1, imem_addr_o=pc_r. On gnt: pc_inflight<=pc_r, pc_r<=pc_r+PC_STEP, ->WAIT.
//         Redir without gnt: stay REQ, new address next cycle. Redir with gnt: ->DROP (pc_r<=tgt).
//   WAIT: on rvalid: buffer<=(rdata,pc_inflight), valid_F_o<=1, ->IDLE.
//         Redir without rvalid: ->DROP. Redir with rvalid: response discarded, ->IDLE.
//   DROP: on rvalid: discard, ->IDLE. Further redirs only update pc_r.
//  Consume: valid_F_o & !stall_F_i; valid_F_o<=0 unless refilled the same edge.
//  Buffer is empty at every issue, so a response never finds the buffer full; no backpressure on rvalid.
//  Latency: IDLE->REQ 1 cycle; gnt in REQ cycle -> earliest rvalid next cycle -> valid_F_o the cycle after.
//  Redirect -> imem_req_o with target: 1 cycle (from IDLE/REQ), else after stale rvalid + 1.
//  PC arithmetic modulo 2^ADDR_W; 32'hFFFF_FFFF + 1 wraps to 0, no flag.
//  imem_addr_o holds stable while req high unless a redirect occurs; imem_req_o=0 outside REQ.
//  rvalid in IDLE/REQ is a protocol error; ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch_o[31:0] (responses written to buffer) and perf_drop_o[31:0]
//   (responses discarded), both reset to 0, saturating at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, gnt=1 always, rvalid 1 cycle after gnt, stall=0 -> addrs 8000_0000,8000_0001,...; pc_F_o matches; no gaps but IDLE bubble.
//  2 stall_F_i=1 for 5 cycles with valid_F_o=1 -> instr/pc held; no new imem_req_o until stall drops.
//  3 redirect_D_i=1, target 8000_0100 while in WAIT -> flush_D_o=1 that cycle, next rvalid discarded, next req addr 8000_0100.
//  4 trap_i and redirect_D_i same cycle (trap_vec 8000_0004) -> next req addr 8000_0004.
//  5 gnt withheld 3 cycles, redirect on cycle 2 -> imem_addr_o changes to target, req stays high, no DROP.
//  6 PC at FFFF_FFFF granted -> next req addr 0000_0000; with FETCH_PERF_EN, test 3 gives perf_drop_o=1.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response port between the fetch sequencer (master) and imem (slave).
// Handshake: req/addr are offered until gnt; each granted request gets exactly one rvalid/rdata
// beat, at least one cycle after gnt; rvalid has no backpressure.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues single-outstanding imem requests, buffers one
// instruction for decode. Optional FETCH_PERF_EN adds saturating fetch/drop counters.
module fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_F_i,
    input  logic              redirect_D_i,
    input  logic [ADDR_W-1:0] target_D_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    fetch_ctrl_if.master      imem,
    output logic              valid_F_o,
    output logic [31:0]       instr_F_o,
    output logic [ADDR_W-1:0] pc_F_o,
    output logic              flush_D_o,
    output logic [1:0]        state_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_drop_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_infl_q, pc_infl_d;
    logic [ADDR_W-1:0] pc_F_q, pc_F_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              redir;
    logic [ADDR_W-1:0] tgt;
    logic              consume;
    logic              fill;

    always_comb begin
        redir     = trap_i | redirect_D_i;
        tgt       = trap_i ? trap_vec_i : target_D_i;
        consume   = valid_q & ~stall_F_i;
        state_d   = state_q;
        pc_d      = pc_q;
        pc_infl_d = pc_infl_q;
        pc_F_d    = pc_F_q;
        instr_d   = instr_q;
        fill      = 1'b0;
        case (state_q)
            // A redirect empties the buffer, so it also frees IDLE to issue.
            S_IDLE: if (!valid_q || consume || redir) state_d = S_REQ;
            S_REQ: begin
                if (imem.gnt) begin
                    if (redir) begin
                        state_d = S_DROP;
                    end else begin
                        pc_infl_d = pc_q;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_d = S_IDLE;
                    if (!redir) begin
                        fill    = 1'b1;
                        instr_d = imem.rdata;
                        pc_F_d  = pc_infl_q;
                    end
                end else if (redir) begin
                    state_d = S_DROP;
                end
            end
            default: if (imem.rvalid) state_d = S_IDLE;
        endcase
        if (redir) pc_d = tgt;
        valid_d = fill | (valid_q & ~consume & ~redir);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pc_infl_q <= RESET_PC;
            pc_F_q    <= RESET_PC;
            instr_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_infl_q <= pc_infl_d;
            pc_F_q    <= pc_F_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

    assign imem.req  = (state_q == S_REQ);
    assign imem.addr = pc_q;
    assign valid_F_o = valid_q;
    assign instr_F_o = instr_q;
    assign pc_F_o    = pc_F_q;
    assign flush_D_o = redir;
    assign state_o   = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_drop_q;
    logic        discard;

    // A response is dropped when it lands in DROP or races a redirect in WAIT.
    assign discard = imem.rvalid && ((state_q == S_DROP) || (state_q == S_WAIT && redir));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (fill && perf_fetch_q != 32'hFFFF_FFFF) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (discard && perf_drop_q != 32'hFFFF_FFFF) perf_drop_q <= perf_drop_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_drop_o  = perf_drop_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: randomized imem slave and redirect traffic checked every cycle against a
// transaction-level model, plus directed scenarios with hand-computed addresses.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_F, redirect_D, trap;
    logic [31:0] target_D, trap_vec;
    logic        valid_F, flush_D;
    logic [31:0] instr_F, pc_F;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_drop;
`endif

    fetch_ctrl_if #(.ADDR_W(32)) imem ();

    fetch_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .PC_STEP(32'd1)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_F_i    (stall_F),
        .redirect_D_i (redirect_D),
        .target_D_i   (target_D),
        .trap_i       (trap),
        .trap_vec_i   (trap_vec),
        .imem         (imem),
        .valid_F_o    (valid_F),
        .instr_F_o    (instr_F),
        .pc_F_o       (pc_F),
        .flush_D_o    (flush_D),
        .state_o      (state)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_drop_o  (perf_drop)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_pct = 100;
    int lat_min = 0;
    int lat_max = 0;
    bit chk_en = 1'b0;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];      // addresses of granted requests awaiting a response
    bit          stale_q[$];
    int          ready_q[$];
    logic [31:0] grant_log[$];
    int          grant_cyc[$];

    logic [31:0] m_pc, m_instr, m_pcF;
    bit          m_valid;
    int unsigned m_fetch, m_drop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- imem slave ----------------
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (rst) begin
            imem.gnt    = 1'b0;
            imem.rvalid = 1'b0;
            imem.rdata  = 32'h0;
        end else begin
            imem.gnt = imem.req && ($urandom_range(99) < gnt_pct);
            if (exp_q.size() > 0 && cyc >= ready_q[0]) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mem_word(exp_q[0]);
            end else begin
                imem.rvalid = 1'b0;
                imem.rdata  = $urandom;
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    always @(negedge clk) begin
        bit          redir, grant, fill, consume, st;
        logic [31:0] tgt, a;
        if (!rst && chk_en) begin
            redir = redirect_D | trap;
            tgt   = trap ? trap_vec : target_D;
            chk("valid_F", {31'b0, valid_F}, {31'b0, m_valid});
            if (m_valid) begin
                chk("instr_F", instr_F, m_instr);
                chk("pc_F", pc_F, m_pcF);
            end
            chk("flush_D", {31'b0, flush_D}, {31'b0, redir});
            if (imem.req) begin
                chk("imem_addr", imem.addr, m_pc);
                chk("req_outstanding", 32'(exp_q.size()), 32'd0);
                chk("req_buffer_empty", {31'b0, m_valid}, 32'd0);
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetch", perf_fetch, m_fetch);
            chk("perf_drop", perf_drop, m_drop);
`endif
            grant   = imem.req && imem.gnt;
            consume = m_valid && !stall_F;
            fill    = 1'b0;
            if (imem.rvalid && exp_q.size() > 0) begin
                a  = exp_q.pop_front();
                st = stale_q.pop_front();
                void'(ready_q.pop_front());
                if (st || redir) begin
                    m_drop++;
                end else begin
                    fill    = 1'b1;
                    m_instr = mem_word(a);
                    m_pcF   = a;
                    m_fetch++;
                end
            end
            if (redir) foreach (stale_q[i]) stale_q[i] = 1'b1;
            if (grant) begin
                exp_q.push_back(m_pc);
                stale_q.push_back(redir);
                ready_q.push_back(cyc + 1 + int'($urandom_range(lat_max, lat_min)));
                grant_log.push_back(m_pc);
                grant_cyc.push_back(cyc);
            end
            m_pc    = redir ? tgt : (grant ? m_pc + 32'd1 : m_pc);
            m_valid = fill || (m_valid && !consume && !redir);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (grant_log.size() < n && k < 300);
        checks++;
        if (grant_log.size() < n) begin
            errors++;
            $display("FAIL %s: timeout, got %0d grants expected %0d", name, grant_log.size(), n);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (valid_F !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (valid_F !== 1'b1) begin
            errors++;
            $display("FAIL %s: timeout, got valid_F %b expected 1", name, valid_F);
        end
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (imem.req !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (imem.req !== 1'b1) begin
            errors++;
            $display("FAIL %s: timeout, got req %b expected 1", name, imem.req);
        end
    endtask

    // One-cycle redirect issued with grants suppressed so no stale grant lands in the log.
    task automatic redirect_once(input logic [31:0] tgt_a, input bit use_trap, input logic [31:0] vec);
        gnt_pct    = 0;
        redirect_D = 1'b1;
        target_D   = tgt_a;
        trap       = use_trap;
        trap_vec   = vec;
        step();
        redirect_D = 1'b0;
        trap       = 1'b0;
        gnt_pct    = 100;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int req_seen;
        rst        = 1'b1;
        stall_F    = 1'b0;
        redirect_D = 1'b0;
        trap       = 1'b0;
        target_D   = 32'h0;
        trap_vec   = 32'h0;
        m_pc       = RST_PC;
        m_pcF      = RST_PC;
        m_instr    = 32'h0;
        m_valid    = 1'b0;
        m_fetch    = 0;
        m_drop     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem.req}, 32'd0);
        chk("rst_addr", imem.addr, 32'h8000_0000);
        chk("rst_valid", {31'b0, valid_F}, 32'd0);
        chk("rst_instr", instr_F, 32'h0);
        chk("rst_pc_F", pc_F, 32'h8000_0000);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch, 32'd0);
        chk("rst_perf_drop", perf_drop, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // streaming, always granted, one-cycle response
        wait_grants(3, "t1_grants");
        chk("t1_addr0", grant_log[0], 32'h8000_0000);
        chk("t1_addr1", grant_log[1], 32'h8000_0001);
        chk("t1_addr2", grant_log[2], 32'h8000_0002);
        chk("t1_spacing01", 32'(grant_cyc[1] - grant_cyc[0]), 32'd3);
        chk("t1_spacing12", 32'(grant_cyc[2] - grant_cyc[1]), 32'd3);

        // stall with a full buffer: no new request, outputs held
        stall_F = 1'b1;
        wait_valid("t2_fill");
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_valid_held", {31'b0, valid_F}, 32'd1);
            chk("t2_no_req", {31'b0, imem.req}, 32'd0);
            step();
        end
        stall_F = 1'b0;

        // redirect while waiting for a response
        lat_min = 2;
        lat_max = 2;
        n = grant_log.size() + 1;
        wait_grants(n, "t3_pre_grant");
        lat_min = 0;
        lat_max = 0;
        redirect_D = 1'b1;
        target_D   = 32'h8000_0100;
        @(negedge clk);
        chk("t3_flush", {31'b0, flush_D}, 32'd1);
        step();
        redirect_D = 1'b0;
        n = grant_log.size() + 1;
        wait_grants(n, "t3_grant");
        chk("t3_addr", grant_log[n-1], 32'h8000_0100);
`ifdef FETCH_PERF_EN
        chk("t3_perf_drop", perf_drop, 32'd1);
`endif

        // trap wins over a simultaneous decode redirect
        n = grant_log.size() + 1;
        redirect_once(32'h8000_0300, 1'b1, 32'h8000_0004);
        wait_grants(n, "t4_grant");
        chk("t4_addr", grant_log[n-1], 32'h8000_0004);

        // grant withheld, redirect on the second request cycle
        gnt_pct = 0;
        wait_req("t5_req");
        step();
        redirect_D = 1'b1;
        target_D   = 32'h8000_0200;
        step();
        redirect_D = 1'b0;
        @(negedge clk);
        chk("t5_req_held", {31'b0, imem.req}, 32'd1);
        chk("t5_addr_new", imem.addr, 32'h8000_0200);
        step();
        n = grant_log.size() + 1;
        gnt_pct = 100;
        wait_grants(n, "t5_grant");
        chk("t5_grant_addr", grant_log[n-1], 32'h8000_0200);
        wait_valid("t5_fill");
        chk("t5_pc_F", pc_F, 32'h8000_0200);

        // PC wrap at the top of the address space
        n = grant_log.size() + 1;
        redirect_once(32'hFFFF_FFFF, 1'b0, 32'h0);
        wait_grants(n + 1, "t6_grants");
        chk("t6_addr_top", grant_log[n-1], 32'hFFFF_FFFF);
        chk("t6_addr_wrap", grant_log[n], 32'h0000_0000);

        // randomized traffic
        gnt_pct = 60;
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            stall_F    = ($urandom_range(3) == 0);
            redirect_D = ($urandom_range(9) == 0);
            trap       = ($urandom_range(24) == 0);
            target_D   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFE + $urandom_range(1)
                                                  : RST_PC + $urandom_range(255);
            trap_vec   = RST_PC + {$urandom_range(15), 2'b00};
            step();
        end
        stall_F    = 1'b0;
        redirect_D = 1'b0;
        trap       = 1'b0;
        repeat (20) step();
        chk("rand_progress", {31'b0, (grant_log.size() > 300)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
